// File: rtl/h14rx_word_align.sv
// TMDS word aligner: hunts for a run of control tokens, issuing deserializer bitslips
// until the word boundary is found, then watches for tokens to detect loss of lock.
module h14rx_word_align #(
  parameter int unsigned TokenRun  = 8,
  parameter int unsigned Window    = 4096,
  parameter int unsigned SlipWait  = 8,
  parameter int unsigned LossLimit = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  output logic [9:0] dout,
  output logic       bitslip,
  output logic       aligned,
  output logic [3:0] slip_count
);

  localparam int unsigned WinW = $clog2(Window);

  localparam logic [1:0] StSearch = 2'd0;
  localparam logic [1:0] StSlip   = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StLocked = 2'd3;

  localparam logic [WinW-1:0] WinLast  = WinW'(Window - 1);
  localparam logic [7:0]      RunLast  = 8'(TokenRun - 1);
  localparam logic [7:0]      WaitLast = 8'(SlipWait - 1);
  localparam logic [3:0]      MissLast = 4'(LossLimit - 1);

  logic [1:0]      state_q, state_d;
  logic [7:0]      run_q, run_d;
  logic [WinW-1:0] win_q, win_d;
  logic [7:0]      wait_q, wait_d;
  logic [3:0]      miss_q, miss_d;
  logic            seen_q, seen_d;
  logic [3:0]      slip_q, slip_d;
  logic [9:0]      dout_q;
  logic            token;
  logic            win_end;

  assign token = (din == 10'b1101010100) || (din == 10'b0010101011) ||
                 (din == 10'b0101010100) || (din == 10'b1010101011);

  assign win_end = (win_q == WinLast);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    win_d   = win_q;
    wait_d  = wait_q;
    miss_d  = miss_q;
    seen_d  = seen_q;
    slip_d  = slip_q;
    case (state_q)
      StSearch: begin
        win_d = win_q + 1'b1;
        run_d = token ? run_q + 8'd1 : 8'd0;
        // A run completing on the last window cycle wins over the slip.
        if (token && (run_q == RunLast)) begin
          state_d = StLocked;
          run_d   = 8'd0;
          win_d   = '0;
          miss_d  = 4'd0;
          seen_d  = 1'b0;
        end else if (win_end) begin
          state_d = StSlip;
          run_d   = 8'd0;
          win_d   = '0;
        end
      end
      StSlip: begin
        slip_d  = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
        wait_d  = 8'd0;
        state_d = StWait;
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          state_d = StSearch;
          run_d   = 8'd0;
          win_d   = '0;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StLocked: begin
        win_d = win_end ? '0 : win_q + 1'b1;
        if (win_end) begin
          seen_d = 1'b0;
          if (seen_q || token) begin
            miss_d = 4'd0;
          end else if (miss_q == MissLast) begin
            state_d = StSearch;
            miss_d  = 4'd0;
            slip_d  = 4'd0;
            run_d   = 8'd0;
            win_d   = '0;
          end else begin
            miss_d = miss_q + 4'd1;
          end
        end else begin
          seen_d = seen_q || token;
          if (token) begin
            miss_d = 4'd0;
          end
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StSearch;
      run_q   <= 8'd0;
      win_q   <= '0;
      wait_q  <= 8'd0;
      miss_q  <= 4'd0;
      seen_q  <= 1'b0;
      slip_q  <= 4'd0;
      dout_q  <= 10'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      win_q   <= win_d;
      wait_q  <= wait_d;
      miss_q  <= miss_d;
      seen_q  <= seen_d;
      slip_q  <= slip_d;
      dout_q  <= din;
    end
  end

  assign dout       = dout_q;
  assign bitslip    = (state_q == StSlip);
  assign aligned    = (state_q == StLocked);
  assign slip_count = slip_q;

endmodule
